// File: rtl/pr_hrav_dispatcher_pkg.sv
// Package: pr_hrav_dispatcher_pkg
// Purpose: definitions shared by the dispatcher read-side scheduler and the FIFO top.
//   - Default descriptor width and engine count.
//   - FSM state encoding used by the scheduler.
// Optional statistics counters in the scheduler are enabled by the macro
// PR_HRAV_DISPATCHER_STATS_EN.
package pr_hrav_dispatcher_pkg;

    localparam int unsigned DefDataSize = 305;
    localparam int unsigned DefNumEng   = 4;

    localparam int unsigned StateW = 3;

    localparam logic [StateW-1:0] StIdle   = 3'd0;
    localparam logic [StateW-1:0] StSettle = 3'd1;
    localparam logic [StateW-1:0] StPop    = 3'd2;
    localparam logic [StateW-1:0] StArb    = 3'd3;
    localparam logic [StateW-1:0] StIssue  = 3'd4;

endpackage

// File: rtl/pr_hrav_dispatcher_rr_arb.sv
// Module: pr_hrav_dispatcher_rr_arb
// Purpose: combinational round-robin pick. Searches elig starting at the engine
//   after last_grant and wrapping, and returns the first eligible engine.
// Ports:
//   elig_i       eligible engines (ready & mask)
//   last_grant_i index of the most recently granted engine
//   grant_o      one-hot grant (zero when nothing is eligible)
//   grant_idx_o  index of the granted engine
//   any_o        at least one engine is eligible
module pr_hrav_dispatcher_rr_arb
    import pr_hrav_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_ENG = DefNumEng,
    localparam int unsigned IdxW   = $clog2(NUM_ENG)
) (
    input  logic [NUM_ENG-1:0] elig_i,
    input  logic [IdxW-1:0]    last_grant_i,
    output logic [NUM_ENG-1:0] grant_o,
    output logic [IdxW-1:0]    grant_idx_o,
    output logic               any_o
);

    logic [IdxW-1:0] cand;
    logic            found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        // Offsets 1..NUM_ENG visit every engine once, ending on last_grant itself.
        for (int unsigned off = 1; off <= NUM_ENG; off++) begin
            cand = IdxW'((32'(last_grant_i) + off) % NUM_ENG);
            if (!found && elig_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/pr_hrav_dispatcher_sched.sv
// Module: pr_hrav_dispatcher_sched
// Purpose: read-side scheduler for the dispatcher async FIFO (rclk domain).
//   Waits for a descriptor, lets the FIFO RAM read settle, pops it, then hands
//   it to one engine chosen round-robin among ready & enabled engines. One
//   descriptor is in flight at a time.
// Ports:
//   rclk, rrst_n   read clock, async active-low reset
//   fifo_rdata_i   FIFO read data
//   fifo_rempty_i  FIFO empty flag
//   fifo_rinc_o    pop strobe, one cycle per descriptor
//   enable_i       allows new descriptors to be started
//   eng_mask_i     per-engine enable
//   eng_ready_i    per-engine ready
//   eng_valid_o    one-hot valid to the engines
//   eng_data_o     descriptor to the engines, stable while valid
//   busy_o         scheduler not idle
//   disp_count_o   completed handshakes (saturating)
//   stall_count_o  arbitration cycles with no eligible engine (saturating)
// Configuration: define PR_HRAV_DISPATCHER_STATS_EN to build the counters;
//   otherwise both counter ports are tied to zero.
module pr_hrav_dispatcher_sched
    import pr_hrav_dispatcher_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DefDataSize,
    parameter int unsigned NUM_ENG   = DefNumEng,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic [DATA_SIZE-1:0] fifo_rdata_i,
    input  logic                 fifo_rempty_i,
    output logic                 fifo_rinc_o,
    input  logic                 enable_i,
    input  logic [NUM_ENG-1:0]   eng_mask_i,
    input  logic [NUM_ENG-1:0]   eng_ready_i,
    output logic [NUM_ENG-1:0]   eng_valid_o,
    output logic [DATA_SIZE-1:0] eng_data_o,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     disp_count_o,
    output logic [CNT_W-1:0]     stall_count_o
);

    localparam int unsigned IdxW = $clog2(NUM_ENG);

    logic [StateW-1:0]    state_q, state_d;
    logic [1:0]           settle_q, settle_d;
    logic [DATA_SIZE-1:0] hold_q, hold_d;
    logic [NUM_ENG-1:0]   valid_q, valid_d;
    logic [IdxW-1:0]      grant_idx_q, grant_idx_d;
    logic [IdxW-1:0]      last_grant_q, last_grant_d;

    logic [NUM_ENG-1:0]   arb_grant;
    logic [IdxW-1:0]      arb_idx;
    logic                 arb_any;
    logic                 handshake;

    pr_hrav_dispatcher_rr_arb #(
        .NUM_ENG (NUM_ENG)
    ) u_rr_arb (
        .elig_i       (eng_ready_i & eng_mask_i),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx),
        .any_o        (arb_any)
    );

    assign handshake = (state_q == StIssue) && |(eng_ready_i & valid_q);

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        hold_d       = hold_q;
        valid_d      = valid_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        case (state_q)
            StIdle: begin
                if (enable_i && !fifo_rempty_i) begin
                    state_d  = StSettle;
                    settle_d = 2'(RD_LAT - 1);
                end
            end
            StSettle: begin
                if (settle_q == 2'd0) state_d = StPop;
                else                  settle_d = settle_q - 2'd1;
            end
            StPop: begin
                hold_d  = fifo_rdata_i;
                state_d = StArb;
            end
            StArb: begin
                // Grant is committed here; later mask/ready changes cannot move it.
                if (arb_any) begin
                    valid_d     = arb_grant;
                    grant_idx_d = arb_idx;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (handshake) begin
                    last_grant_d = grant_idx_q;
                    valid_d      = '0;
                    state_d      = StIdle;
                end
            end
            default: begin
                valid_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q      <= StIdle;
            settle_q     <= '0;
            hold_q       <= '0;
            valid_q      <= '0;
            grant_idx_q  <= '0;
            last_grant_q <= IdxW'(NUM_ENG - 1);
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            hold_q       <= hold_d;
            valid_q      <= valid_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign fifo_rinc_o = (state_q == StPop);
    assign busy_o      = (state_q != StIdle);
    assign eng_valid_o = valid_q;
    assign eng_data_o  = hold_q;

`ifdef PR_HRAV_DISPATCHER_STATS_EN
    logic [CNT_W-1:0] disp_q, stall_q;
    logic             stall;

    assign stall = (state_q == StArb) && !arb_any;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            disp_q  <= '0;
            stall_q <= '0;
        end else begin
            if (handshake && (disp_q != '1)) disp_q <= disp_q + CNT_W'(1);
            if (stall && (stall_q != '1))    stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign disp_count_o  = disp_q;
    assign stall_count_o = stall_q;
`else
    assign disp_count_o  = '0;
    assign stall_count_o = '0;
`endif

endmodule
